// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared constants, state encoding and strobe bundle
// for the RTC parallel-bus responder.
package rtc_bus_pkg;

    localparam int BUS_W = 8;
    localparam logic [BUS_W-1:0] CMD_ADDR_DEF = 8'hFF;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR_STB = 3'd1;
    localparam logic [2:0] ST_ADDR_OK  = 3'd2;
    localparam logic [2:0] ST_DATA_WR  = 3'd3;
    localparam logic [2:0] ST_DATA_RD  = 3'd4;

    typedef struct packed {
        logic ad;
        logic cs;
        logic rd;
        logic wr;
    } strobe_t;

    localparam strobe_t STB_IDLE = '{ad: 1'b0, cs: 1'b1, rd: 1'b1, wr: 1'b1};

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rtc_strobe_sync.sv
// rtc_strobe_sync: one register stage on the raw bus strobes and data,
// with CS edge pulses derived from the registered copy.
module rtc_strobe_sync
    import rtc_bus_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ad,
    input  logic             i_cs,
    input  logic             i_rd,
    input  logic             i_wr,
    input  logic [BUS_W-1:0] i_bus,
    output strobe_t          o_stb,
    output logic [BUS_W-1:0] o_bus,
    output logic             o_cs_fall,
    output logic             o_cs_rise
);
    strobe_t          r_stb;
    logic [BUS_W-1:0] r_bus;
    logic             r_cs_d;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stb  <= STB_IDLE;
            r_bus  <= '0;
            r_cs_d <= 1'b1;
        end else begin
            r_stb  <= '{ad: i_ad, cs: i_cs, rd: i_rd, wr: i_wr};
            r_bus  <= i_bus;
            r_cs_d <= r_stb.cs;
        end
    end

    assign o_stb     = r_stb;
    assign o_bus     = r_bus;
    assign o_cs_fall = r_cs_d & ~r_stb.cs;
    assign o_cs_rise = ~r_cs_d & r_stb.cs;

endmodule

// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder: responder end of the multiplexed RTC bus, with a small
// register file standing in for the RTC chip and sticky protocol checkers.
module rtc_bus_responder
    import rtc_bus_pkg::*;
#(
    parameter int               NUM_REGS   = 16,
    parameter logic [BUS_W-1:0] CMD_ADDR   = CMD_ADDR_DEF,
    parameter int               MIN_STROBE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             AD,
    input  logic             CS,
    input  logic             RD,
    input  logic             WR,
    input  logic [BUS_W-1:0] bus_in,
    output logic [BUS_W-1:0] bus_out,
    output logic             bus_oe,
    output logic             cmd_strobe,
    output logic             wr_event,
    output logic [BUS_W-1:0] cur_addr,
    output logic             timing_err,
    output logic             proto_err
);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [BUS_W-1:0] NREG = BUS_W'(NUM_REGS);
    localparam logic [7:0] MINW = 8'(MIN_STROBE);

    strobe_t          w_stb;
    logic [BUS_W-1:0] w_bus;
    logic             w_cs_fall;
    logic             w_cs_rise;

    rtc_strobe_sync u_sync (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_ad      (AD),
        .i_cs      (CS),
        .i_rd      (RD),
        .i_wr      (WR),
        .i_bus     (bus_in),
        .o_stb     (w_stb),
        .o_bus     (w_bus),
        .o_cs_fall (w_cs_fall),
        .o_cs_rise (w_cs_rise)
    );

    logic [2:0]       r_state;
    logic [BUS_W-1:0] r_addr;
    logic [BUS_W-1:0] r_regs [NUM_REGS];
    logic [7:0]       r_cnt;
    logic             r_wr_lo;
    logic             r_both;
    logic             r_oe;
    logic             r_cmd;
    logic             r_wev;
    logic             r_terr;
    logic             r_perr;

    logic             w_both_now;
    logic             w_in_range;
    logic             w_is_cmd;
    logic             w_go_rd;
    logic             w_commit;
    logic             w_commit_reg;
    logic             w_commit_cmd;
    logic             w_bad_strobe;
    logic [BUS_W-1:0] w_rd_data;

    assign w_both_now   = ~w_stb.cs & ~w_stb.rd & ~w_stb.wr;
    assign w_in_range   = r_addr < NREG;
    assign w_is_cmd     = r_addr == CMD_ADDR;
    assign w_go_rd      = (r_state == ST_ADDR_OK) & w_cs_fall & w_stb.ad
                        & w_stb.wr & ~w_stb.rd;
    assign w_commit     = (r_state == ST_DATA_WR) & w_cs_rise & ~r_both;
    assign w_commit_reg = w_commit & w_in_range;
    assign w_commit_cmd = w_commit & w_is_cmd;
    // both strobes low, a data phase from IDLE, or a read in the address phase
    assign w_bad_strobe = w_both_now
                        | ((r_state == ST_IDLE) & w_cs_fall & w_stb.ad)
                        | (~w_stb.cs & ~w_stb.ad & ~w_stb.rd);
    assign w_rd_data    = w_in_range ? r_regs[r_addr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_wr_lo <= 1'b0;
            r_both  <= 1'b0;
            r_oe    <= 1'b0;
            r_cmd   <= 1'b0;
            r_wev   <= 1'b0;
            r_terr  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_cmd <= w_commit_cmd;
            r_wev <= w_commit_reg | w_commit_cmd;
            r_oe  <= ~w_stb.cs & ~w_stb.rd & w_stb.wr
                   & ((r_state == ST_DATA_RD) | w_go_rd);
            if (!w_stb.cs) begin
                r_cnt   <= w_cs_fall ? 8'd1 : sat_inc8(r_cnt);
                r_wr_lo <= (~w_cs_fall & r_wr_lo) | ~w_stb.wr;
                r_both  <= (~w_cs_fall & r_both) | w_both_now;
            end
            if (w_cs_rise && r_cnt < MINW) r_terr <= 1'b1;
            if (w_bad_strobe) r_perr <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall && !w_stb.ad) r_state <= ST_ADDR_STB;
                end
                ST_ADDR_STB: begin
                    if (w_cs_rise) begin
                        if (r_wr_lo && !r_both) begin
                            r_addr  <= w_bus;
                            r_state <= ST_ADDR_OK;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_ADDR_OK: begin
                    if (w_cs_fall) begin
                        if (!w_stb.ad) r_state <= ST_ADDR_STB;
                        else if (!w_stb.wr) r_state <= ST_DATA_WR;
                        else if (!w_stb.rd) r_state <= ST_DATA_RD;
                    end
                end
                ST_DATA_WR, ST_DATA_RD: begin
                    if (w_cs_rise) r_state <= r_both ? ST_IDLE : ST_ADDR_OK;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_commit_reg) begin
            r_regs[r_addr[AW-1:0]] <= w_bus;
        end
    end

    // gating on the live registered strobes drops the drive as soon as CS rises
    assign bus_oe     = r_oe & ~w_stb.cs & w_stb.wr;
    assign bus_out    = bus_oe ? w_rd_data : '0;
    assign cmd_strobe = r_cmd;
    assign wr_event   = r_wev;
    assign cur_addr   = r_addr;
    assign timing_err = r_terr;
    assign proto_err  = r_perr;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// tb_rtc_bus_responder: table-driven write/read vectors plus hand-written
// sequences for strobe errors and reset during a read.
module tb_rtc_bus_responder;

    logic       clk;
    logic       reset;
    logic       AD, CS, RD, WR;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       cmd_strobe;
    logic       wr_event;
    logic [7:0] cur_addr;
    logic       timing_err;
    logic       proto_err;

    rtc_bus_responder dut (
        .clk        (clk),
        .reset      (reset),
        .AD         (AD),
        .CS         (CS),
        .RD         (RD),
        .WR         (WR),
        .bus_in     (bus_in),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe),
        .cmd_strobe (cmd_strobe),
        .wr_event   (wr_event),
        .cur_addr   (cur_addr),
        .timing_err (timing_err),
        .proto_err  (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int n_wev   = 0;
    int n_cmd   = 0;
    int cmd_run = 0;
    int cmd_max = 0;

    always @(negedge clk) begin
        if (wr_event) n_wev++;
        if (cmd_strobe) begin
            n_cmd++;
            cmd_run++;
            if (cmd_run > cmd_max) cmd_max = cmd_run;
        end else begin
            cmd_run = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    logic       x_oe_first;
    logic       x_oe_after;
    int         x_oe_cnt;
    logic [7:0] x_data;

    // one CS pulse, low for n clocks, bus held until after the rise
    task automatic xfer(input bit ad, input bit rd, input bit wr,
                        input logic [7:0] d, input int n);
        AD = ad; bus_in = d; CS = 0; RD = rd; WR = wr;
        x_oe_first = 0; x_oe_cnt = 0; x_data = 8'h00;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            if (i == 1) x_oe_first = bus_oe;
            if (bus_oe) begin
                x_oe_cnt++;
                x_data = bus_out;
            end
        end
        CS = 1; RD = 1; WR = 1;
        @(posedge clk); #1;
        x_oe_after = bus_oe;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        bit         is_rd;
        int         exp_wev;
        int         exp_cmd;
        logic [7:0] exp_q;
    } vec_t;

    vec_t vt[11];

    initial begin
        int w0, c0;
        vt[0]  = '{8'h05, 8'h3C, 1'b0, 1, 0, 8'h00};
        vt[1]  = '{8'h05, 8'h00, 1'b1, 0, 0, 8'h3C};
        vt[2]  = '{8'h0F, 8'hA5, 1'b0, 1, 0, 8'h00};
        vt[3]  = '{8'h0F, 8'h00, 1'b1, 0, 0, 8'hA5};
        vt[4]  = '{8'hFF, 8'h00, 1'b0, 1, 1, 8'h00};
        vt[5]  = '{8'hFF, 8'h00, 1'b1, 0, 0, 8'h00};
        vt[6]  = '{8'h20, 8'hAA, 1'b0, 0, 0, 8'h00};
        vt[7]  = '{8'h20, 8'h00, 1'b1, 0, 0, 8'h00};
        vt[8]  = '{8'h10, 8'h77, 1'b0, 0, 0, 8'h00};
        vt[9]  = '{8'h05, 8'h00, 1'b1, 0, 0, 8'h3C};
        vt[10] = '{8'h00, 8'h00, 1'b1, 0, 0, 8'h00};

        AD = 0; CS = 1; RD = 1; WR = 1; bus_in = 8'h00; reset = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_oe", bus_oe, 0);
        chk("rst_out", bus_out, 0);
        chk("rst_addr", cur_addr, 0);
        chk("rst_flags", {timing_err, proto_err, cmd_strobe, wr_event}, 0);
        reset = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            w0 = n_wev; c0 = n_cmd;
            xfer(0, 1, 0, vt[i].addr, 3);
            chk($sformatf("v%0d_addr", i), cur_addr, vt[i].addr);
            if (vt[i].is_rd) begin
                xfer(1, 0, 1, 8'h00, 4);
                chk($sformatf("v%0d_rdata", i), x_data, vt[i].exp_q);
                chk($sformatf("v%0d_oe_cnt", i), x_oe_cnt, 3);
                chk($sformatf("v%0d_oe_early", i), x_oe_first, 0);
                chk($sformatf("v%0d_oe_after", i), x_oe_after, 0);
            end else begin
                xfer(1, 1, 0, vt[i].data, 3);
            end
            chk($sformatf("v%0d_wev", i), n_wev - w0, vt[i].exp_wev);
            chk($sformatf("v%0d_cmd", i), n_cmd - c0, vt[i].exp_cmd);
            chk($sformatf("v%0d_errs", i), {timing_err, proto_err}, 0);
        end
        chk("cmd_width", cmd_max, 1);

        // repeated data cycles reuse the latched address
        w0 = n_wev;
        xfer(0, 1, 0, 8'h03, 3);
        xfer(1, 1, 0, 8'h11, 3);
        xfer(1, 1, 0, 8'h22, 3);
        chk("rep_wev", n_wev - w0, 2);
        chk("rep_addr", cur_addr, 8'h03);
        xfer(1, 0, 1, 8'h00, 3);
        chk("rep_rdata", x_data, 8'h22);

        // data phase straight after reset
        do_reset();
        w0 = n_wev;
        xfer(1, 1, 0, 8'h55, 3);
        chk("noaddr_perr", proto_err, 1);
        chk("noaddr_wev", n_wev - w0, 0);
        chk("noaddr_terr", timing_err, 0);

        // short CS pulse still latches the address
        do_reset();
        xfer(0, 1, 0, 8'h05, 1);
        chk("short_terr", timing_err, 1);
        chk("short_perr", proto_err, 0);
        chk("short_addr", cur_addr, 8'h05);

        // RD and WR low together
        do_reset();
        w0 = n_wev;
        xfer(0, 1, 0, 8'h02, 3);
        xfer(1, 0, 0, 8'h99, 3);
        chk("both_perr", proto_err, 1);
        chk("both_wev", n_wev - w0, 0);
        chk("both_terr", timing_err, 0);
        xfer(0, 1, 0, 8'h02, 3);
        xfer(1, 0, 1, 8'h00, 3);
        chk("both_rdata", x_data, 8'h00);

        // RD low in an address phase
        do_reset();
        xfer(0, 0, 1, 8'h01, 3);
        chk("addr_rd_perr", proto_err, 1);

        // reset during a read
        do_reset();
        xfer(0, 1, 0, 8'h04, 3);
        xfer(1, 1, 0, 8'h5A, 3);
        xfer(0, 1, 0, 8'h04, 1);
        AD = 1; bus_in = 8'h00; CS = 0; RD = 0; WR = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_oe", bus_oe, 1);
        chk("mid_data", bus_out, 8'h5A);
        chk("mid_terr", timing_err, 1);
        reset = 0;
        @(posedge clk); #1;
        chk("mid_rst_oe", bus_oe, 0);
        chk("mid_rst_flags", {timing_err, proto_err}, 0);
        chk("mid_rst_addr", cur_addr, 0);
        CS = 1; RD = 1;
        @(posedge clk); #1;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        w0 = n_wev;
        xfer(0, 1, 0, 8'h01, 3);
        xfer(1, 1, 0, 8'hC3, 3);
        chk("post_wev", n_wev - w0, 1);
        xfer(1, 0, 1, 8'h00, 4);
        chk("post_rdata", x_data, 8'hC3);
        xfer(0, 1, 0, 8'h04, 3);
        xfer(1, 0, 1, 8'h00, 4);
        chk("post_cleared", x_data, 8'h00);
        chk("post_errs", {timing_err, proto_err}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
